// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared defines, widths and types for the reorder buffer
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 5
`endif
`ifndef NUM_REGISTERS_LOG2
`define NUM_REGISTERS_LOG2 5
`endif
`ifndef ROB_DATA_W
`define ROB_DATA_W 32
`endif

package reorder_buffer_pkg;
    localparam int ROB_ENTRIES_LOG2 = `NUM_IQ_ENTRIES_LOG2;
    localparam int ROB_ENTRIES      = 1 << ROB_ENTRIES_LOG2;
    localparam int REG_W            = `NUM_REGISTERS_LOG2;
    localparam int DATA_W           = `ROB_DATA_W;
    localparam int CNT_W            = ROB_ENTRIES_LOG2 + 1;
    typedef logic [ROB_ENTRIES_LOG2-1:0] tag_t;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam tag_t TAG_ONE = tag_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam cnt_t RDY_MAX = cnt_t'(ROB_ENTRIES - 2);
endpackage

// File: rtl/rob_retire_sel.sv
// rob_retire_sel: selects up to two in-order retirements starting at head
module rob_retire_sel
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_ENTRIES-1:0]      vld,
    input  logic [ROB_ENTRIES-1:0]      done,
    input  logic [ROB_ENTRIES_LOG2-1:0] head,
    output logic [ROB_ENTRIES_LOG2-1:0] head_p1,
    output logic                        pop0,
    output logic                        pop1,
    output logic [1:0]                  head_inc
);
    assign head_p1  = head + TAG_ONE;
    assign pop0     = vld[head] & done[head];
    assign pop1     = pop0 & vld[head_p1] & done[head_p1];
    assign head_inc = {1'b0, pop0} + {1'b0, pop1};
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 32-entry circular ROB, 2-wide alloc/writeback/retire; ROB_SPEC_FLUSH_EN selects partial flush
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [ROB_ENTRIES_LOG2-1:0] flush_rob_addr,
    input  logic                        push0,
    input  logic                        push1,
    input  logic                        spec0,
    input  logic                        spec1,
    input  logic [REG_W-1:0]            push_reg_addr0,
    input  logic [REG_W-1:0]            push_reg_addr1,
    output logic [ROB_ENTRIES_LOG2-1:0] alloc_rob_addr0,
    output logic [ROB_ENTRIES_LOG2-1:0] alloc_rob_addr1,
    output logic                        alloc_rdy,
    input  logic                        wb0,
    input  logic                        wb1,
    input  logic [ROB_ENTRIES_LOG2-1:0] wb_rob_addr0,
    input  logic [ROB_ENTRIES_LOG2-1:0] wb_rob_addr1,
    input  logic [DATA_W-1:0]           wb_data0,
    input  logic [DATA_W-1:0]           wb_data1,
    output logic                        pop0,
    output logic                        pop1,
    output logic [REG_W-1:0]            pop_reg_addr0,
    output logic [REG_W-1:0]            pop_reg_addr1,
    output logic [ROB_ENTRIES_LOG2-1:0] pop_rob_addr0,
    output logic [ROB_ENTRIES_LOG2-1:0] pop_rob_addr1,
    output logic [DATA_W-1:0]           pop_data0,
    output logic [DATA_W-1:0]           pop_data1,
    output logic [CNT_W-1:0]            count
);
    tag_t                   head, tail, head_p1, tail_p1;
    logic [ROB_ENTRIES-1:0] vld, done, spec;
    logic [REG_W-1:0]       reg_q  [ROB_ENTRIES];
    logic [DATA_W-1:0]      data_q [ROB_ENTRIES];
    logic [1:0]             head_inc;
    logic                   acc0, acc1;
    cnt_t                   count_next;
    logic                   unused;

    rob_retire_sel u_retire_sel (
        .vld      (vld),
        .done     (done),
        .head     (head),
        .head_p1  (head_p1),
        .pop0     (pop0),
        .pop1     (pop1),
        .head_inc (head_inc)
    );

    assign tail_p1         = tail + TAG_ONE;
    assign alloc_rob_addr0 = tail;
    assign alloc_rob_addr1 = tail_p1;
    assign alloc_rdy       = count <= RDY_MAX;
    assign acc0            = push0 & alloc_rdy & ~flush;
    assign acc1            = acc0 & push1;
    assign count_next      = count + cnt_t'(acc0) + cnt_t'(acc1) - cnt_t'(head_inc);
    assign pop_rob_addr0   = pop0 ? head : '0;
    assign pop_rob_addr1   = pop1 ? head_p1 : '0;
    assign pop_reg_addr0   = pop0 ? reg_q[head] : '0;
    assign pop_reg_addr1   = pop1 ? reg_q[head_p1] : '0;
    assign pop_data0       = pop0 ? data_q[head] : '0;
    assign pop_data1       = pop1 ? data_q[head_p1] : '0;
    assign unused          = ^{spec, flush_rob_addr};

`ifdef ROB_SPEC_FLUSH_EN
    tag_t                   span;
    cnt_t                   keep_cnt;
    logic [ROB_ENTRIES-1:0] younger;
    assign span     = flush_rob_addr - head;
    assign keep_cnt = cnt_t'(span) + CNT_ONE - cnt_t'(head_inc);
    // Entries past flush_rob_addr in age order are the ones a partial flush discards
    always_comb begin
        younger = '0;
        for (int i = 0; i < ROB_ENTRIES; i++)
            younger[i] = (tag_t'(i) - head) > span;
    end
`endif

    // Entry state and pointers: writeback, retire, allocate, then flush overrides
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
            done  <= '0;
            spec  <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (wb0 && vld[wb_rob_addr0]) begin
                done[wb_rob_addr0]   <= 1'b1;
                data_q[wb_rob_addr0] <= wb_data0;
            end
            if (wb1 && vld[wb_rob_addr1]) begin
                done[wb_rob_addr1]   <= 1'b1;
                data_q[wb_rob_addr1] <= wb_data1;
            end
            if (pop0) vld[head] <= 1'b0;
            if (pop1) vld[head_p1] <= 1'b0;
            if (acc0) begin
                vld[tail]   <= 1'b1;
                done[tail]  <= 1'b0;
                spec[tail]  <= spec0;
                reg_q[tail] <= push_reg_addr0;
            end
            if (acc1) begin
                vld[tail_p1]   <= 1'b1;
                done[tail_p1]  <= 1'b0;
                spec[tail_p1]  <= spec1;
                reg_q[tail_p1] <= push_reg_addr1;
            end
            head  <= head + tag_t'(head_inc);
            tail  <= tail + tag_t'(acc0) + tag_t'(acc1);
            count <= count_next;
            if (flush) begin
`ifdef ROB_SPEC_FLUSH_EN
                vld   <= vld & ~younger & ~(ROB_ENTRIES'(pop0) << head) & ~(ROB_ENTRIES'(pop1) << head_p1);
                tail  <= flush_rob_addr + TAG_ONE;
                count <= keep_cnt;
`else
                vld   <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: randomized + directed bench against a queue-based ROB model (honours ROB_SPEC_FLUSH_EN)
module tb_reorder_buffer;
    logic        clk = 0;
    logic        reset = 0;
    logic        flush = 0;
    logic [4:0]  flush_rob_addr = 0;
    logic        push0 = 0, push1 = 0, spec0 = 0, spec1 = 0;
    logic [4:0]  push_reg_addr0 = 0, push_reg_addr1 = 0;
    logic [4:0]  alloc_rob_addr0, alloc_rob_addr1;
    logic        alloc_rdy;
    logic        wb0 = 0, wb1 = 0;
    logic [4:0]  wb_rob_addr0 = 0, wb_rob_addr1 = 0;
    logic [31:0] wb_data0 = 0, wb_data1 = 0;
    logic        pop0, pop1;
    logic [4:0]  pop_reg_addr0, pop_reg_addr1, pop_rob_addr0, pop_rob_addr1;
    logic [31:0] pop_data0, pop_data1;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          tag;
        int          rg;
        logic [31:0] data;
        bit          done;
    } ent_t;
    ent_t q[$];
    int   head_tag = 0;

    reorder_buffer dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_rob_addr(flush_rob_addr),
        .push0(push0), .push1(push1), .spec0(spec0), .spec1(spec1),
        .push_reg_addr0(push_reg_addr0), .push_reg_addr1(push_reg_addr1),
        .alloc_rob_addr0(alloc_rob_addr0), .alloc_rob_addr1(alloc_rob_addr1), .alloc_rdy(alloc_rdy),
        .wb0(wb0), .wb1(wb1), .wb_rob_addr0(wb_rob_addr0), .wb_rob_addr1(wb_rob_addr1),
        .wb_data0(wb_data0), .wb_data1(wb_data1),
        .pop0(pop0), .pop1(pop1), .pop_reg_addr0(pop_reg_addr0), .pop_reg_addr1(pop_reg_addr1),
        .pop_rob_addr0(pop_rob_addr0), .pop_rob_addr1(pop_rob_addr1),
        .pop_data0(pop_data0), .pop_data1(pop_data1), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int tail_tag();
        return (head_tag + q.size()) % 32;
    endfunction

    function automatic int exp_pops();
        int n = 0;
        if (q.size() > 0 && q[0].done) begin
            n = 1;
            if (q.size() > 1) begin
                if (q[1].done) n = 2;
            end
        end
        return n;
    endfunction

    task automatic check_outputs();
        int t = tail_tag();
        int np = exp_pops();
        chk("count", 64'(count), 64'(q.size()));
        chk("alloc_rdy", 64'(alloc_rdy), 64'(q.size() <= 30));
        chk("alloc0", 64'(alloc_rob_addr0), 64'(t));
        chk("alloc1", 64'(alloc_rob_addr1), 64'((t + 1) % 32));
        chk("pop0", 64'(pop0), 64'(np >= 1));
        chk("pop1", 64'(pop1), 64'(np == 2));
        chk("pop_rob0", 64'(pop_rob_addr0), np >= 1 ? 64'(q[0].tag) : 64'(0));
        chk("pop_reg0", 64'(pop_reg_addr0), np >= 1 ? 64'(q[0].rg) : 64'(0));
        chk("pop_data0", 64'(pop_data0), np >= 1 ? 64'(q[0].data) : 64'(0));
        chk("pop_rob1", 64'(pop_rob_addr1), np == 2 ? 64'(q[1].tag) : 64'(0));
        chk("pop_reg1", 64'(pop_reg_addr1), np == 2 ? 64'(q[1].rg) : 64'(0));
        chk("pop_data1", 64'(pop_data1), np == 2 ? 64'(q[1].data) : 64'(0));
    endtask

    task automatic model_edge();
        int  np = exp_pops();
        int  t = tail_tag();
        bit  a0 = !flush && q.size() <= 30 && push0;
        bit  a1 = a0 && push1;
        if (wb0) foreach (q[i]) if (q[i].tag == int'(wb_rob_addr0)) begin q[i].done = 1; q[i].data = wb_data0; end
        if (wb1) foreach (q[i]) if (q[i].tag == int'(wb_rob_addr1)) begin q[i].done = 1; q[i].data = wb_data1; end
        repeat (np) void'(q.pop_front());
        head_tag = (head_tag + np) % 32;
        if (flush) begin
`ifdef ROB_SPEC_FLUSH_EN
            int k = -1;
            foreach (q[i]) if (q[i].tag == int'(flush_rob_addr)) k = i;
            while (q.size() > k + 1) void'(q.pop_back());
`else
            q.delete();
            head_tag = 0;
`endif
        end else begin
            if (a0) q.push_back('{t, int'(push_reg_addr0), 32'h0, 1'b0});
            if (a1) q.push_back('{(t + 1) % 32, int'(push_reg_addr1), 32'h0, 1'b0});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        push0 = 0; push1 = 0; wb0 = 0; wb1 = 0; flush = 0;
    endtask

    task automatic set_push(input bit p0, input bit p1);
        push0 = p0; push1 = p1;
        spec0 = 1'($urandom); spec1 = 1'($urandom);
        push_reg_addr0 = 5'($urandom); push_reg_addr1 = 5'($urandom);
    endtask

    task automatic pick_wb(input int n, input bit rnd);
        int idx[$];
        foreach (q[i]) if (!q[i].done) idx.push_back(i);
        if (n > 0 && idx.size() > 0) begin
            wb0 = 1; wb_data0 = $urandom;
            wb_rob_addr0 = 5'(q[idx[rnd ? $urandom_range(0, idx.size() - 1) : 0]].tag);
        end
        if (n > 1 && idx.size() > 1) begin
            wb1 = 1; wb_data1 = $urandom;
            wb_rob_addr1 = 5'(q[idx[rnd ? $urandom_range(0, idx.size() - 1) : 1]].tag);
        end
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() > 0 && g < 200) begin
            pick_wb(2, 0);
            cycle();
            g++;
        end
        if (g >= 200) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic do_reset();
        #2 reset = 0;
        #1;
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_pop0", 64'(pop0), 64'(0));
        chk("rst_alloc0", 64'(alloc_rob_addr0), 64'(0));
        q.delete();
        head_tag = 0;
        @(negedge clk);
        reset = 1;
        check_outputs();
    endtask

    initial begin
        int g;
        repeat (2) @(negedge clk);
        reset = 1;
        check_outputs();

        // fill to capacity; the 17th push must be ignored
        for (int i = 0; i < 17; i++) begin set_push(1, 1); cycle(); end
        chk("fill_count", 64'(count), 64'(32));
        chk("fill_rdy", 64'(alloc_rdy), 64'(0));

        // out-of-order completion holds retirement until tag 0 is done
        wb0 = 1; wb_rob_addr0 = 5'd1; wb_data0 = 32'hA1A1_0001; cycle();
        chk("ooo_nopop", 64'(pop0), 64'(0));
        wb0 = 1; wb_rob_addr0 = 5'd0; wb_data0 = 32'hB0B0_0000; cycle();
        chk("ooo_pop1", 64'(pop1), 64'(1));
        chk("ooo_data1", 64'(pop_data1), 64'(32'hA1A1_0001));
        drain();

        // walk head/tail to 30, then allocate across the wrap point
        g = 0;
        while (!(head_tag == 30 && q.size() == 0) && g < 100) begin
            if (tail_tag() != 30) set_push(1, 1);
            pick_wb(2, 0);
            cycle();
            g++;
        end
        chk("wrap_reach30", 64'(alloc_rob_addr0), 64'(30));
        set_push(1, 1); cycle();
        chk("wrap_tag0", 64'(alloc_rob_addr0), 64'(0));
        set_push(1, 1); cycle();
        drain();
        chk("wrap_head", 64'(alloc_rob_addr0), 64'(2));
        chk("wrap_count", 64'(count), 64'(0));

        // asynchronous reset with live traffic
        set_push(1, 1); cycle();
        set_push(1, 1); cycle();
        set_push(1, 0); cycle();
        pick_wb(1, 0); cycle();
        chk("pre_rst_pop0", 64'(pop0), 64'(1));
        do_reset();

        // flush with tags 0..9 live
        for (int i = 0; i < 5; i++) begin set_push(1, 1); cycle(); end
`ifdef ROB_SPEC_FLUSH_EN
        flush = 1; flush_rob_addr = 5'd4;
        wb0 = 1; wb_rob_addr0 = 5'd7; wb_data0 = 32'hDEAD_0007;
        set_push(1, 1);
        cycle();
        chk("flush_count", 64'(count), 64'(5));
        chk("flush_tail", 64'(alloc_rob_addr0), 64'(5));
        set_push(1, 1); cycle();
        set_push(1, 1); cycle();
        drain();
`else
        wb0 = 1; wb_rob_addr0 = 5'd0; wb_data0 = 32'h1234_5678; cycle();
        chk("flush_pop0", 64'(pop0), 64'(1));
        flush = 1; flush_rob_addr = 5'd4; set_push(1, 1); cycle();
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_tail", 64'(alloc_rob_addr0), 64'(0));
`endif

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            set_push($urandom_range(0, 3) != 0, 1'($urandom));
            if ($urandom_range(0, 9) < 7) pick_wb($urandom_range(1, 2), 1);
            else if ($urandom_range(0, 1) == 0) begin
                wb0 = 1; wb_rob_addr0 = 5'($urandom); wb_data0 = $urandom;
            end
            if ($urandom_range(0, 40) == 0) begin
`ifdef ROB_SPEC_FLUSH_EN
                int np = exp_pops();
                if (q.size() > np) begin
                    flush = 1;
                    flush_rob_addr = 5'(q[$urandom_range(np, q.size() - 1)].tag);
                end
`else
                flush = 1;
                flush_rob_addr = 5'($urandom);
`endif
            end
            cycle();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
